// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch initiator for the single-issue RV32I core.
//            Owns the program counter, presents word addresses to an
//            asynchronous-read instruction memory and buffers fetched words
//            with their PCs in a 2-entry queue that feeds decode through a
//            valid/ready handshake. Redirects from execute reload the PC and
//            flush the queue.
// Ports    : clk, rst_n               - clock, async active-low reset
//            fetch_en                 - allow a fetch this cycle
//            imem_addr / imem_rdata   - instruction memory address / word
//            redirect_valid/_pc       - control transfer from execute
//            out_valid / out_ready    - decode handshake
//            out_instr, out_pc,
//            out_pc_plus4             - head entry contents
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam logic [1:0] c_FULL = 2'(DEPTH);

  logic [31:0] r_pc;
  logic [31:0] r_instr [0:1];
  logic [31:0] r_qpc   [0:1];
  logic        r_rptr;
  logic        r_wptr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic        w_unused;

  // Low target bits are dropped; the redirect always lands word aligned.
  assign w_unused = &{1'b0, redirect_pc[1:0]};

  assign w_pop  = (r_count != 2'd0) & out_ready;
  // A full queue still accepts a word when the head leaves in the same cycle,
  // which keeps throughput at one per cycle after backpressure releases.
  assign w_push = fetch_en & ~redirect_valid & ((r_count != c_FULL) | w_pop);

  assign imem_addr    = r_pc;
  assign out_valid    = (r_count != 2'd0);
  assign out_instr    = r_instr[r_rptr];
  assign out_pc       = r_qpc[r_rptr];
  assign out_pc_plus4 = r_qpc[r_rptr] + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= 32'd0;
        r_qpc[i]   <= 32'd0;
      end
    end else if (redirect_valid) begin
      // Flush: any head popped this cycle is already delivered, the rest is
      // discarded by resetting occupancy and pointers.
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_instr[r_wptr] <= imem_rdata;
        r_qpc[r_wptr]   <= r_pc;
        r_wptr          <= ~r_wptr;
        r_pc            <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch initiator for the single-issue RV32I core. It owns the program counter, drives word addresses into the asynchronous-read instruction memory, and buffers fetched words with their PCs in a 2-entry queue. The queue feeds decode through a valid/ready handshake. Control transfers from execute (branches, `jal`) redirect the PC and flush everything queued.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word aligned.
- `DEPTH`, default 2: queue entries. Only 2 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_en`  in  1  allows a fetch this cycle.
- `imem_addr`  out  32  byte address of the current fetch PC. Equals the fetch PC combinationally.
- `imem_rdata`  in  32  instruction word returned by memory in the same cycle (combinational read).
- `redirect_valid`  in  1  redirect request from execute.
- `redirect_pc`  in  32  redirect target. Bits [1:0] are ignored.
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head instruction.
- `out_instr`  out  32  instruction word at the queue head.
- `out_pc`  out  32  PC of the head instruction.
- `out_pc_plus4`  out  32  `out_pc + 4`, mod 2^32.

## Operation
- State:
  - `pc` register.
  - Queue of 2 entries, each {instr, pc}.
  - Read pointer, write pointer, and `count` (0..2).
- `pop` = `out_valid & out_ready`.
- `push` = `fetch_en & ~redirect_valid & (count<2 | pop)`.
- On push:
  - Write {`imem_rdata`, `pc`} to the tail.
  - `pc <= pc + 4`. Wraps 32'hFFFF_FFFC to 32'h0000_0000.
- On redirect (`redirect_valid=1`):
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `count <= 0` and pointers reset, which discards all queued entries.
  - No push this cycle.
  - A head consumed by `pop` in the same cycle counts as delivered. Redirect has priority over every other action.
- Push and pop in the same cycle: `count` is unchanged. This is legal when full.
- Pop with no push: `count` decrements. Push with no pop: `count` increments.
- `fetch_en=0`: PC is held and nothing is pushed. Pops still drain the queue.
- Outputs are read from the head entry:
  - `out_valid = (count != 0)`.
  - When `out_valid=0`, `out_instr`, `out_pc` and `out_pc_plus4` show the stale head contents. Decode must ignore them.
- Queue entries never change while valid, which keeps the head stable while `out_ready=0`.

## Timing
- Reset (async assert, sync-safe release):
  - `pc = RESET_PC`, `count = 0`, pointers 0, all entries cleared to 0.
  - Therefore `imem_addr = RESET_PC`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `out_pc_plus4 = 4`.
- Fetch latency: the word at PC X, pushed at edge N, is visible on `out_*` after edge N (`out_valid=1` in cycle N+1), provided the queue was empty.
- Redirect latency:
  - `redirect_valid` sampled at edge N.
  - `imem_addr` shows the target in cycle N+1. The target is pushed at edge N+1.
  - `out_valid` reads 0 in cycle N+1 and reads 1 with the target from cycle N+2.
- Steady state: with `out_ready=1` and `fetch_en=1`, throughput is 1 instruction/cycle with no bubbles.
- Backpressure: with `out_ready=0`, the queue fills in 2 cycles and then `pc` freezes. When `out_ready` rises, throughput resumes at once, because push and pop are allowed in the same cycle when full.
- Reset asserted mid-stream: queue contents are lost immediately and `out_valid` drops asynchronously.

## Test plan
- Reset then sequential fetch:
  - Stimulus: `RESET_PC=0`, memory returns word index i for address 4i, `fetch_en=1`, `out_ready=1`.
  - Required: `out_valid` first high the cycle after reset release. The stream is `out_pc` 0,4,8,… with `out_instr` 0,1,2,… and no gaps.
- Backpressure:
  - Stimulus: `out_ready=0` for 5 cycles from cycle 1.
  - Required: `count` saturates at 2 and `imem_addr` holds 8. The head stays at pc 0 (instr 0). After `out_ready=1` the stream continues 0,4,8,12 with no loss and no duplicates.
- Redirect with a full queue:
  - Stimulus: queue holds pc 8 and 12, then `redirect_valid=1` with `redirect_pc=32'h0000_0023`.
  - Required: next cycle `out_valid=0` and `imem_addr=32'h20`. The cycle after, `out_pc=32'h20` and `out_pc_plus4=32'h24`. Entries 8 and 12 never reappear.
- Redirect simultaneous with pop:
  - Stimulus: head at pc 4 with `out_ready=1` and `redirect_valid=1` in the same cycle.
  - Required: pc 4 is accepted exactly once. The next delivered PC is the redirect target.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFF8.
  - Required: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000. `out_pc_plus4` for FFFF_FFFC is 0.
- Async reset mid-operation:
  - Stimulus: assert `rst_n=0` between edges while the queue holds 2 entries.
  - Required: `out_valid` falls before the next edge. After release, fetch restarts at `RESET_PC`.
